// File: rtl/iic_dsmod_ctrl.sv
// Sample-feed and configuration controller for the delta-sigma modulator.
// Buffers upstream samples, feeds the modulator on its fetch strobe and sequences enable/reset/config.
module iic_dsmod_ctrl #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] MIDSCALE = 16'h8000
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     enable_i,
    input  logic [15:0]              in_data_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic                     cfg_mode_i,
    input  logic [3:0]               cfg_scale_i,
    input  logic [1:0]               cfg_osr_i,
    input  logic                     cfg_upd_i,
    output logic [15:0]              ds_data_o,
    input  logic                     ds_rd_i,
    output logic                     mode_o,
    output logic [3:0]               scale_o,
    output logic [1:0]               osr_o,
    output logic                     mod_rst_n_o,
    output logic [$clog2(DEPTH):0]   fill_o,
    output logic                     underflow_o,
    input  logic                     underflow_clr_i
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL  = (AW+1)'(DEPTH);
    localparam logic [AW:0] PRIME_LVL = (AW+1)'(2);

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    logic [1:0]  state;
    logic [1:0]  next_state;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] fill;
    logic [15:0] mem [DEPTH];
    logic        push;
    logic        pop;
    logic        ds_fetch;
    logic        uf_set;
    logic        sh_mode;
    logic [3:0]  sh_scale;
    logic [1:0]  sh_osr;

    // Readiness uses the registered fill only, so a full FIFO refuses a push even when popped.
    assign fill       = wr_ptr - rd_ptr;
    assign fill_o     = fill;
    assign in_ready_o = rst_n_i & enable_i & (fill < FULL_LVL);
    assign push       = in_valid_i & in_ready_o;
    assign ds_fetch   = enable_i & (state == ST_RUN) & ds_rd_i;
    assign uf_set     = ds_fetch & (fill == '0);
    assign pop        = (enable_i & (state == ST_PRIME) & (fill >= PRIME_LVL))
                      | (ds_fetch & (fill != '0));

    always_comb begin
        next_state = state;
        if (!enable_i) begin
            next_state = ST_OFF;
        end else begin
            case (state)
                ST_OFF:   next_state = ST_PRIME;
                ST_PRIME: next_state = (fill >= PRIME_LVL) ? ST_RUN : ST_PRIME;
                ST_RUN:   next_state = ST_RUN;
                default:  next_state = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= ST_OFF;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ds_data_o   <= MIDSCALE;
            mod_rst_n_o <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            state       <= next_state;
            mod_rst_n_o <= (next_state == ST_RUN);
            underflow_o <= uf_set | (underflow_o & ~underflow_clr_i);
            if (!enable_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
            // The popped word lands together with mod_rst_n_o rising on entry to RUN.
            if (next_state != ST_RUN)
                ds_data_o <= MIDSCALE;
            else if (pop)
                ds_data_o <= mem[rd_ptr[AW-1:0]];
            else if (uf_set)
                ds_data_o <= MIDSCALE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr[AW-1:0]] <= in_data_i;
    end

    // Active config only moves at a sample boundary while running, so osr/mode never glitch mid-sample.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sh_mode  <= 1'b0;
            sh_scale <= '0;
            sh_osr   <= '0;
            mode_o   <= 1'b0;
            scale_o  <= '0;
            osr_o    <= '0;
        end else begin
            if (cfg_upd_i) begin
                sh_mode  <= cfg_mode_i;
                sh_scale <= cfg_scale_i;
                sh_osr   <= cfg_osr_i;
            end
            if ((state != ST_RUN) || ds_rd_i) begin
                mode_o  <= sh_mode;
                scale_o <= sh_scale;
                osr_o   <= sh_osr;
            end
        end
    end

endmodule

// File: tb/tb_iic_dsmod_ctrl.sv
// Self-checking bench for iic_dsmod_ctrl: directed start-up/underflow/full/config/disable/reset
// scenarios followed by randomized traffic, all checked against a queue-based reference model.
module tb_iic_dsmod_ctrl;

    localparam int          DEPTH = 4;
    localparam logic [15:0] MID   = 16'h8000;
    localparam int M_OFF = 0, M_PRIME = 1, M_RUN = 2;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        enable_i = 1'b0;
    logic [15:0] in_data_i = '0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic        cfg_mode_i = 1'b0;
    logic [3:0]  cfg_scale_i = '0;
    logic [1:0]  cfg_osr_i = '0;
    logic        cfg_upd_i = 1'b0;
    logic [15:0] ds_data_o;
    logic        ds_rd_i = 1'b0;
    logic        mode_o;
    logic [3:0]  scale_o;
    logic [1:0]  osr_o;
    logic        mod_rst_n_o;
    logic [2:0]  fill_o;
    logic        underflow_o;
    logic        underflow_clr_i = 1'b0;

    int tests = 0;
    int failures = 0;

    logic [15:0] q[$];
    int          m_state;
    logic [15:0] m_data;
    logic        m_uf;
    logic        sh_mode, act_mode;
    logic [3:0]  sh_scale, act_scale;
    logic [1:0]  sh_osr, act_osr;

    iic_dsmod_ctrl #(.DEPTH(DEPTH), .MIDSCALE(MID)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .enable_i(enable_i),
        .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .cfg_mode_i(cfg_mode_i), .cfg_scale_i(cfg_scale_i), .cfg_osr_i(cfg_osr_i),
        .cfg_upd_i(cfg_upd_i), .ds_data_o(ds_data_o), .ds_rd_i(ds_rd_i),
        .mode_o(mode_o), .scale_o(scale_o), .osr_o(osr_o), .mod_rst_n_o(mod_rst_n_o),
        .fill_o(fill_o), .underflow_o(underflow_o), .underflow_clr_i(underflow_clr_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        q.delete();
        m_state = M_OFF;
        m_data = MID;
        m_uf = 1'b0;
        {sh_mode, sh_scale, sh_osr} = '0;
        {act_mode, act_scale, act_osr} = '0;
    endtask

    // Advance the reference by one clock using the inputs currently driven.
    task automatic modelStep();
        bit room;
        bit uf_set;
        bit copy;
        room = (q.size() < DEPTH);
        uf_set = 0;
        copy = (m_state != M_RUN) || ds_rd_i;
        if (!enable_i) begin
            m_state = M_OFF;
            q.delete();
            m_data = MID;
        end else begin
            case (m_state)
                M_OFF: m_state = M_PRIME;
                M_PRIME: if (q.size() >= 2) begin
                    m_data = q.pop_front();
                    m_state = M_RUN;
                end
                default: if (ds_rd_i) begin
                    if (q.size() > 0) m_data = q.pop_front();
                    else begin
                        m_data = MID;
                        uf_set = 1;
                    end
                end
            endcase
            if (in_valid_i && room) q.push_back(in_data_i);
        end
        if (copy) {act_mode, act_scale, act_osr} = {sh_mode, sh_scale, sh_osr};
        if (cfg_upd_i) {sh_mode, sh_scale, sh_osr} = {cfg_mode_i, cfg_scale_i, cfg_osr_i};
        m_uf = uf_set | (m_uf & ~underflow_clr_i);
    endtask

    task automatic compareAll();
        checkOutput("ds_data", ds_data_o, m_data);
        checkOutput("fill", fill_o, q.size());
        checkOutput("mod_rst_n", mod_rst_n_o, (m_state == M_RUN));
        checkOutput("underflow", underflow_o, m_uf);
        checkOutput("mode", mode_o, act_mode);
        checkOutput("scale", scale_o, act_scale);
        checkOutput("osr", osr_o, act_osr);
    endtask

    task automatic compareReset();
        checkOutput("rst_ds_data", ds_data_o, MID);
        checkOutput("rst_fill", fill_o, 0);
        checkOutput("rst_in_ready", in_ready_o, 0);
        checkOutput("rst_mod_rst_n", mod_rst_n_o, 0);
        checkOutput("rst_underflow", underflow_o, 0);
        checkOutput("rst_cfg", {mode_o, scale_o, osr_o}, 0);
    endtask

    task automatic applyStimulus(input logic en, input logic vld, input logic [15:0] d,
                                 input logic rd, input logic upd, input logic clr);
        enable_i = en;
        in_valid_i = vld;
        in_data_i = d;
        ds_rd_i = rd;
        cfg_upd_i = upd;
        underflow_clr_i = clr;
        #1;
        checkOutput("in_ready", in_ready_o, (en && q.size() < DEPTH));
        modelStep();
        @(posedge clk_i);
        #1;
        compareAll();
    endtask

    initial begin
        logic prev_rd;
        modelReset();
        enable_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        compareReset();
        enable_i = 1'b0;
        rst_n_i = 1'b1;

        // Start-up: two pushes prime the FIFO, first sample presented as the modulator leaves reset.
        applyStimulus(1, 1, 16'h1234, 0, 0, 0);
        applyStimulus(1, 1, 16'h5678, 0, 0, 0);
        applyStimulus(1, 0, 16'h0000, 0, 0, 0);
        checkOutput("su_data", ds_data_o, 16'h1234);
        checkOutput("su_mod_rst_n", mod_rst_n_o, 1);
        checkOutput("su_fill", fill_o, 1);

        applyStimulus(1, 0, 0, 1, 0, 0);
        checkOutput("pop2_data", ds_data_o, 16'h5678);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 0);
        checkOutput("uf_data", ds_data_o, 16'h8000);
        checkOutput("uf_flag", underflow_o, 1);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 1);
        checkOutput("uf_set_clr", underflow_o, 1);
        applyStimulus(1, 0, 0, 0, 0, 1);
        checkOutput("uf_cleared", underflow_o, 0);

        cfg_mode_i = 1'b1;
        cfg_scale_i = 4'd2;
        cfg_osr_i = 2'd3;
        applyStimulus(1, 0, 0, 0, 1, 0);
        checkOutput("cfg_hold_osr", osr_o, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("cfg_hold_scale", scale_o, 0);
        checkOutput("cfg_hold_mode", mode_o, 0);
        applyStimulus(1, 0, 0, 1, 0, 0);
        checkOutput("cfg_osr", osr_o, 3);
        checkOutput("cfg_scale", scale_o, 2);
        applyStimulus(1, 0, 0, 0, 0, 1);

        for (int i = 0; i < DEPTH; i++) applyStimulus(1, 1, 16'hA000 + 16'(i), 0, 0, 0);
        checkOutput("full_fill", fill_o, DEPTH);
        checkOutput("full_ready", in_ready_o, 0);
        applyStimulus(1, 1, 16'hBEEF, 1, 0, 0);
        checkOutput("full_pop_fill", fill_o, DEPTH - 1);
        checkOutput("full_pop_data", ds_data_o, 16'hA000);

        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("off_fill", fill_o, 0);
        checkOutput("off_mod_rst_n", mod_rst_n_o, 0);
        checkOutput("off_data", ds_data_o, 16'h8000);

        applyStimulus(1, 1, 16'h1111, 0, 0, 0);
        applyStimulus(1, 1, 16'h2222, 0, 0, 0);
        applyStimulus(1, 1, 16'h3333, 0, 0, 0);
        checkOutput("rerun_mod_rst_n", mod_rst_n_o, 1);
        #2;
        rst_n_i = 1'b0;
        #1;
        compareReset();
        modelReset();
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;

        prev_rd = 1'b0;
        for (int n = 0; n < 600; n++) begin
            logic rd;
            logic upd;
            rd = !prev_rd && ($urandom_range(0, 2) == 0);
            upd = ($urandom_range(0, 7) == 0);
            cfg_mode_i = 1'($urandom_range(0, 1));
            cfg_scale_i = 4'($urandom_range(0, 15));
            cfg_osr_i = 2'($urandom_range(0, 3));
            applyStimulus(($urandom_range(0, 24) != 0), 1'($urandom_range(0, 1)),
                          16'($urandom), rd, upd, ($urandom_range(0, 15) == 0));
            prev_rd = rd;
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
